// File: rtl/axi_selftest_pkg.sv
// Shared constants and FSM state encoding for the AXI4-Lite register self-test master.
package axi_selftest_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  localparam logic MODE_INTERLEAVED = 1'b0;
  localparam logic MODE_BLOCK       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_e;
endpackage

// File: rtl/axi_lite_selftest_checker.sv
// Error accounting: saturating error counter, sticky bad-response flag, first-failure capture.
module axi_lite_selftest_checker
  import axi_selftest_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             b_hs,
  input  logic             r_hs,
  input  logic [1:0]       resp,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    exp_data,
  input  logic [DW-1:0]    act_data,
  output logic             txn_fail,
  output logic [ERR_W-1:0] err_count,
  output logic             resp_err,
  output logic [AW-1:0]    fail_addr,
  output logic [DW-1:0]    fail_exp,
  output logic [DW-1:0]    fail_act
);
  logic           bad_resp, mism;
  logic [1:0]     inc;
  logic [ERR_W:0] sum;

  assign bad_resp = (b_hs | r_hs) && (resp != RESP_OKAY);
  assign mism     = r_hs && (act_data != exp_data);
  assign txn_fail = bad_resp | mism;
  assign inc      = {1'b0, bad_resp} + {1'b0, mism};
  assign sum      = {1'b0, err_count} + (ERR_W+1)'(inc);

  // The counter can never return to zero once bumped, so zero means "no failure captured yet".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      resp_err  <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else if (clear) begin
      err_count <= '0;
      resp_err  <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else if (txn_fail) begin
      err_count <= sum[ERR_W] ? '1 : sum[ERR_W-1:0];
      if (bad_resp) resp_err <= 1'b1;
      if (err_count == '0) begin
        fail_addr <= addr;
        if (mism) begin
          fail_exp <= exp_data;
          fail_act <= act_data;
        end
      end
    end
  end
endmodule

// File: rtl/axi_lite_reg_selftest_master.sv
// AXI4-Lite master running a write/readback pattern test over NUM_REGS registers on a start pulse.
module axi_lite_reg_selftest_master
  import axi_selftest_pkg::*;
#(
  parameter int                               C_M_AXI_ADDR_WIDTH = 32,
  parameter int                               C_M_AXI_DATA_WIDTH = 32,
  parameter int                               NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]    BASE_ADDR          = '0,
  parameter int unsigned                      ADDR_STRIDE        = 4,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]    PATTERN_STEP       = C_M_AXI_DATA_WIDTH'(32'h01010101),
  parameter int                               ERR_W              = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            mode,
  input  logic                            stop_on_error,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [ERR_W-1:0]                err_count,
  output logic                            resp_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   fail_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   fail_exp,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   fail_act,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [DW-1:0]    seed_q, cur_data;
  logic [AW-1:0]    cur_addr;
  logic             mode_q, stop_q, req_issued, aw_done, w_done;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, last, txn_fail, chk_clear;

  assign cur_addr = BASE_ADDR + AW'(idx) * AW'(ADDR_STRIDE);
  assign cur_data = seed_q + DW'(idx) * PATTERN_STEP;
  assign last     = (idx == IDX_W'(NUM_REGS - 1));

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs  = (state == ST_WR_RESP) && M_AXI_BVALID && M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = (state == ST_RD_RESP) && M_AXI_RVALID && M_AXI_RREADY;
  assign chk_clear = (state == ST_IDLE) && start;

  // Address/data derive from idx, which only moves on a response, so they are stable under VALID.
  assign M_AXI_AWADDR = cur_addr;
  assign M_AXI_ARADDR = cur_addr;
  assign M_AXI_WDATA  = cur_data;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  axi_lite_selftest_checker #(.AW(AW), .DW(DW), .ERR_W(ERR_W)) u_chk (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .clear     (chk_clear),
    .b_hs      (b_hs),
    .r_hs      (r_hs),
    .resp      ((state == ST_WR_RESP) ? M_AXI_BRESP : M_AXI_RRESP),
    .addr      (cur_addr),
    .exp_data  (cur_data),
    .act_data  (M_AXI_RDATA),
    .txn_fail  (txn_fail),
    .err_count (err_count),
    .resp_err  (resp_err),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_act  (fail_act)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      idx           <= '0;
      seed_q        <= '0;
      mode_q        <= 1'b0;
      stop_q        <= 1'b0;
      req_issued    <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          busy       <= 1'b1;
          done       <= 1'b0;
          pass       <= 1'b0;
          idx        <= '0;
          seed_q     <= seed;
          mode_q     <= mode;
          stop_q     <= stop_on_error;
          req_issued <= 1'b0;
          state      <= ST_WR_REQ;
        end
        ST_WR_REQ: begin
          if (!req_issued) begin
            req_issued    <= 1'b1;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
          end else begin
            if (aw_hs) begin
              M_AXI_AWVALID <= 1'b0;
              aw_done       <= 1'b1;
            end
            if (w_hs) begin
              M_AXI_WVALID <= 1'b0;
              w_done       <= 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
              M_AXI_BREADY <= 1'b1;
              state        <= ST_WR_RESP;
            end
          end
        end
        ST_WR_RESP: if (b_hs) begin
          M_AXI_BREADY <= 1'b0;
          req_issued   <= 1'b0;
          if (stop_q && txn_fail) state <= ST_DONE;
          else if (mode_q == MODE_INTERLEAVED) state <= ST_RD_REQ;
          else if (last) begin
            idx   <= '0;
            state <= ST_RD_REQ;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_WR_REQ;
          end
        end
        ST_RD_REQ: begin
          if (!req_issued) begin
            req_issued    <= 1'b1;
            M_AXI_ARVALID <= 1'b1;
          end else if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: if (r_hs) begin
          M_AXI_RREADY <= 1'b0;
          req_issued   <= 1'b0;
          if ((stop_q && txn_fail) || last) state <= ST_DONE;
          else begin
            idx   <= idx + 1'b1;
            state <= (mode_q == MODE_BLOCK) ? ST_RD_REQ : ST_WR_REQ;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_selftest_master.sv
// Self-checking bench: memory-backed AXI4-Lite slave with fault injection, event scoreboard.
module tb_axi_lite_reg_selftest_master;
  localparam int AW = 32, DW = 32, ERR_W = 16;
  localparam logic [31:0] STEP = 32'h01010101;

  logic tb_ACLK = 1'b0;
  logic tb_ARESETN = 1'b1;
  always #5 tb_ACLK = ~tb_ACLK;

  logic start = 1'b0, mode = 1'b0, stop_on_error = 1'b0;
  logic [DW-1:0] seed = '0;
  logic busy, done, pass, resp_err;
  logic [ERR_W-1:0] err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_act;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;

  axi_lite_reg_selftest_master dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN), .start(start), .mode(mode),
    .stop_on_error(stop_on_error), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .resp_err(resp_err), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_act(fail_act),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave model knobs
  int aw_delay = 0;
  logic flip_en = 1'b0, berr_en = 1'b0;
  logic [AW-1:0] flip_addr = '0, berr_addr = '0;

  logic [31:0] mem [16];
  logic aw_got, w_got;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  int aw_wait;

  always @(posedge tb_ACLK or negedge tb_ARESETN) begin
    if (!tb_ARESETN) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; aw_addr_q <= '0; w_data_q <= '0;
    end else begin
      awready <= 1'b0;
      if (awvalid && !awready && !aw_got) begin
        if (aw_wait >= aw_delay) begin awready <= 1'b1; aw_wait <= 0; end
        else aw_wait <= aw_wait + 1;
      end
      if (awvalid && awready) begin aw_got <= 1'b1; aw_addr_q <= awaddr; end
      wready <= 1'b0;
      if (wvalid && !wready && !w_got) wready <= 1'b1;
      if (wvalid && wready) begin w_got <= 1'b1; w_data_q <= wdata; end
      if (bvalid && bready) bvalid <= 1'b0;
      if (aw_got && w_got && !bvalid) begin
        mem[aw_addr_q[5:2]] <= w_data_q;
        bresp  <= (berr_en && aw_addr_q == berr_addr) ? 2'b10 : 2'b00;
        bvalid <= 1'b1;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      arready <= 1'b0;
      if (arvalid && !arready && !rvalid) arready <= 1'b1;
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rdata  <= mem[araddr[5:2]] ^ {31'd0, (flip_en && araddr == flip_addr)};
        rresp  <= 2'b00;
        rvalid <= 1'b1;
      end
    end
  end

  // Scoreboard: observed completed transactions vs. expected sequence
  typedef struct packed { logic rd; logic [31:0] addr; logic [31:0] data; } ev_t;
  ev_t obs_q[$], exp_q[$];
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata;

  always @(posedge tb_ACLK) begin
    if (tb_ARESETN) begin
      if (awvalid && awready) m_awaddr <= awaddr;
      if (wvalid && wready) m_wdata <= wdata;
      if (arvalid && arready) m_araddr <= araddr;
      if (bvalid && bready) obs_q.push_back({1'b0, m_awaddr, m_wdata});
      if (rvalid && rready) obs_q.push_back({1'b1, m_araddr, rdata});
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic run_selftest(input logic [31:0] s, input logic m, input logic st,
                              input bit dup_start, output bit to);
    obs_q.delete();
    @(negedge tb_ACLK); seed = s; mode = m; stop_on_error = st; start = 1'b1;
    @(negedge tb_ACLK); start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge tb_ACLK);
      start = (dup_start && c == 4);
      if (done) begin to = 1'b0; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 tb_ARESETN = 1'b0;
    #1;
    n_chk++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) $display("FAIL reset_handshake act=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready}); else n_pass++;
    n_chk++; if ({busy, done, pass, resp_err} !== 4'b0) $display("FAIL reset_status act=%b exp=0000", {busy, done, pass, resp_err}); else n_pass++;
    n_chk++; if (err_count !== '0) $display("FAIL reset_err_count act=%0d exp=0", err_count); else n_pass++;
    n_chk++; if ({fail_addr, fail_exp, fail_act} !== '0) $display("FAIL reset_fail_regs act=%h exp=0", {fail_addr, fail_exp, fail_act}); else n_pass++;
    n_chk++; if ({awprot, arprot, wstrb} !== 10'b000_000_1111) $display("FAIL const_prot_strb act=%b exp=0000001111", {awprot, arprot, wstrb}); else n_pass++;
    repeat (3) @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
  endtask

  task automatic test_interleaved();
    logic [31:0] d [4] = '{32'h0101FFFF, 32'h02030100, 32'h03040201, 32'h04050302};
    bit to; ev_t e, o;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 32'(i * 4), d[i]});
      exp_q.push_back({1'b1, 32'(i * 4), d[i]});
    end
    run_selftest(32'h0101FFFF, 1'b0, 1'b0, 1'b1, to);
    n_chk++; if (to) $display("FAIL t1_timeout act=done_low exp=done_high"); else n_pass++;
    n_chk++; if (obs_q.size() !== exp_q.size()) $display("FAIL t1_txn_count act=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o !== e) $display("FAIL t1_txn act=%h exp=%h", o, e); else n_pass++;
    end
    n_chk++; if ({done, pass, busy} !== 3'b110) $display("FAIL t1_status act=%b exp=110", {done, pass, busy}); else n_pass++;
    n_chk++; if (err_count !== '0) $display("FAIL t1_err_count act=%0d exp=0", err_count); else n_pass++;
  endtask

  task automatic test_block_mode();
    logic [31:0] s = 32'hFFFFFFFF;
    bit to; ev_t e, o;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'(i * 4), s + 32'(i) * STEP});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 32'(i * 4), s + 32'(i) * STEP});
    run_selftest(s, 1'b1, 1'b0, 1'b0, to);
    n_chk++; if (to) $display("FAIL t2_timeout act=done_low exp=done_high"); else n_pass++;
    n_chk++; if (obs_q.size() !== exp_q.size()) $display("FAIL t2_txn_count act=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o !== e) $display("FAIL t2_txn act=%h exp=%h", o, e); else n_pass++;
    end
    n_chk++; if (pass !== 1'b1) $display("FAIL t2_pass act=%b exp=1", pass); else n_pass++;
  endtask

  task automatic test_mismatch(input logic stop);
    logic [31:0] d [4] = '{32'h0101FFFF, 32'h02030100, 32'h03040201, 32'h04050302};
    int n = stop ? 3 : 4;
    bit to; ev_t e, o;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, 32'(i * 4), d[i]});
      exp_q.push_back({1'b1, 32'(i * 4), (i == 2) ? (d[i] ^ 32'h1) : d[i]});
    end
    flip_en = 1'b1; flip_addr = 32'h8;
    run_selftest(32'h0101FFFF, 1'b0, stop, 1'b0, to);
    flip_en = 1'b0;
    n_chk++; if (to) $display("FAIL mism_timeout stop=%b act=done_low exp=done_high", stop); else n_pass++;
    n_chk++; if (obs_q.size() !== exp_q.size()) $display("FAIL mism_txn_count stop=%b act=%0d exp=%0d", stop, obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o !== e) $display("FAIL mism_txn stop=%b act=%h exp=%h", stop, o, e); else n_pass++;
    end
    n_chk++; if (err_count !== 16'd1) $display("FAIL mism_err_count act=%0d exp=1", err_count); else n_pass++;
    n_chk++; if (fail_addr !== 32'h8) $display("FAIL mism_fail_addr act=%h exp=8", fail_addr); else n_pass++;
    n_chk++; if (fail_exp !== 32'h03040201) $display("FAIL mism_fail_exp act=%h exp=03040201", fail_exp); else n_pass++;
    n_chk++; if (fail_act !== 32'h03040200) $display("FAIL mism_fail_act act=%h exp=03040200", fail_act); else n_pass++;
    n_chk++; if ({pass, resp_err} !== 2'b00) $display("FAIL mism_pass_resp act=%b exp=00", {pass, resp_err}); else n_pass++;
  endtask

  task automatic test_bresp_err();
    bit to;
    berr_en = 1'b1; berr_addr = 32'h4;
    run_selftest(32'h0101FFFF, 1'b0, 1'b0, 1'b0, to);
    berr_en = 1'b0;
    n_chk++; if (to) $display("FAIL berr_timeout act=done_low exp=done_high"); else n_pass++;
    n_chk++; if (obs_q.size() !== 8) $display("FAIL berr_txn_count act=%0d exp=8", obs_q.size()); else n_pass++;
    n_chk++; if (resp_err !== 1'b1) $display("FAIL berr_resp_err act=%b exp=1", resp_err); else n_pass++;
    n_chk++; if (err_count !== 16'd1) $display("FAIL berr_err_count act=%0d exp=1", err_count); else n_pass++;
    n_chk++; if (fail_addr !== 32'h4) $display("FAIL berr_fail_addr act=%h exp=4", fail_addr); else n_pass++;
    n_chk++; if ({fail_exp, fail_act} !== 64'h0) $display("FAIL berr_fail_data act=%h exp=0", {fail_exp, fail_act}); else n_pass++;
    n_chk++; if (pass !== 1'b0) $display("FAIL berr_pass act=%b exp=0", pass); else n_pass++;
  endtask

  task automatic test_aw_stall_and_reset();
    logic [AW-1:0] a0;
    int awc = 0, wc = 0;
    bit stable = 1'b1, seen = 1'b0;
    aw_delay = 3;
    obs_q.delete();
    @(negedge tb_ACLK); seed = 32'h0101FFFF; mode = 1'b0; stop_on_error = 1'b0; start = 1'b1;
    @(negedge tb_ACLK); start = 1'b0;
    for (int c = 0; c < 20 && !awvalid; c++) @(negedge tb_ACLK);
    a0 = awaddr;
    for (int c = 0; c < 20 && awvalid; c++) begin
      awc++;
      if (wvalid) wc++;
      if (awaddr !== a0) stable = 1'b0;
      @(negedge tb_ACLK);
    end
    n_chk++; if (awc !== 5) $display("FAIL stall_awvalid_cycles act=%0d exp=5", awc); else n_pass++;
    n_chk++; if (wc !== 2) $display("FAIL stall_wvalid_cycles act=%0d exp=2", wc); else n_pass++;
    n_chk++; if (!stable || a0 !== 32'h0) $display("FAIL stall_awaddr_stable act=%h/%b exp=0/1", a0, stable); else n_pass++;
    for (int c = 0; c < 100; c++) begin
      if (rready) begin seen = 1'b1; break; end
      @(negedge tb_ACLK);
    end
    n_chk++; if (!seen || busy !== 1'b1) $display("FAIL rst_reach_rd_resp act=%b/%b exp=1/1", seen, busy); else n_pass++;
    #1 tb_ARESETN = 1'b0;
    #1;
    n_chk++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) $display("FAIL rst_mid_valids act=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready}); else n_pass++;
    n_chk++; if ({busy, done, pass} !== 3'b0) $display("FAIL rst_mid_status act=%b exp=000", {busy, done, pass}); else n_pass++;
    aw_delay = 0;
    repeat (2) @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_interleaved();
    test_block_mode();
    test_mismatch(1'b0);
    test_mismatch(1'b1);
    test_bresp_err();
    test_aw_stall_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_selftest_master.md
Name: axi_lite_reg_selftest_master

Overview:
Synthesizable AXI4-Lite master that runs a register write/readback self-test against an AXI4-Lite slave on a single start pulse. It writes a generated pattern to NUM_REGS consecutive registers, reads each register back and compares the result. It reports pass/fail, an error count and the first-failure details. It runs on hardware and replaces the BFM-driven simulation check on the GPS AXI slave; it is generalised in register count, width, stride and ordering mode.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, address bus width
C_M_AXI_DATA_WIDTH, 32, data bus width (32 or 64)
NUM_REGS, 4, registers under test (1..256)
BASE_ADDR, 0, address of register 0
ADDR_STRIDE, 4, byte distance between registers
PATTERN_STEP, 32'h01010101, per-index pattern increment
ERR_W, 16, error counter width

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; ignored while busy
mode  in  1  0 = interleaved write/read per register; 1 = all writes, then all reads
stop_on_error  in  1  abort after the first failing transaction
seed  in  DW  pattern for register 0
busy  out  1  test in progress
done  out  1  high from completion until next accepted start
pass  out  1  valid when done; 1 = no errors
err_count  out  ERR_W  saturating mismatch + bad-response count
resp_err  out  1  sticky; any BRESP/RRESP != OKAY
fail_addr  out  AW  address of first failure
fail_exp  out  DW  expected data of first mismatch
fail_act  out  DW  read data of first mismatch
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  AW channel (AWPROT = 3'b000)
M_AXI_WDATA/WSTRB/WVALID/WREADY  W channel (WSTRB all ones)
M_AXI_BRESP/BVALID/BREADY  B channel
M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  AR channel (ARPROT = 3'b000)
M_AXI_RDATA/RRESP/RVALID/RREADY  R channel

Behaviour:
- Reset: all VALID/READY outputs 0; busy 0; done 0; pass 0; err_count 0; resp_err 0; fail_* 0; FSM in IDLE.
- Pattern: data[i] = seed + i*PATTERN_STEP mod 2^DW. Address: addr[i] = BASE_ADDR + i*ADDR_STRIDE, truncated to AW.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: on start, clear err_count, resp_err and fail_*; clear done; set busy; set index to 0; go to WR_REQ.
- WR_REQ:
  - AWVALID and WVALID assert together, registered one cycle after state entry.
  - Each VALID drops independently the cycle after its own handshake. Address and data stay stable while VALID is high.
  - Go to WR_RESP once both handshakes are done.
- WR_RESP: BREADY = 1. On BVALID:
  - mode 0 → RD_REQ, same index.
  - mode 1 → next index in WR_REQ, or index 0 in RD_REQ after the last write.
- RD_REQ: ARVALID held with a stable ARADDR until ARREADY → RD_RESP.
- RD_RESP: RREADY = 1. On RVALID, compare RDATA with data[i], then:
  - mode 0 → WR_REQ at i+1.
  - mode 1 → RD_REQ at i+1.
  - After the last index → DONE.
- Error rules:
  - BRESP != 2'b00 or RRESP != 2'b00: resp_err = 1, err_count + 1.
  - RDATA mismatch: err_count + 1.
  - A read with both a bad RRESP and a mismatch counts 2.
  - err_count saturates at all ones.
  - fail_* are captured only for the first failure. A response-only failure sets fail_addr and leaves fail_exp/fail_act at 0.
- stop_on_error = 1: after a failing B or R handshake, go directly to DONE. No further requests are issued.
- DONE: busy 0, done 1, pass = (err_count == 0), then return to IDLE. done, pass and fail_* hold until the next start.
- At most one outstanding transaction per channel. No new AW/AR is issued until the previous response is received.
- Reset mid-test: everything returns to reset values immediately (asynchronous); partial results are discarded.
- start while busy: ignored, no effect.

Decomposition:
- Shared package axi_selftest_pkg:
  - response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01
  - FSM state enum
  - mode constants MODE_INTERLEAVED, MODE_BLOCK
- Sub-module axi_lite_selftest_checker:
  - inputs: comparison input, response input
  - state held: saturating counter, sticky resp_err, first-failure capture
  - the top level keeps the FSM and the AXI channel logic.

Test Plan:
1. Zero-wait memory slave, mode 0, seed 0x0101FFFF, NUM_REGS 4 → writes 0x0101FFFF, 0x02030100, 0x03040201, 0x04050302 to 0x0/0x4/0x8/0xC, each write followed by its read; done = 1, pass = 1, err_count = 0.
2. Same setup, mode 1 → all four AW handshakes occur before the first AR; pass = 1.
3. Slave flips RDATA bit 0 on address 0x8, stop_on_error = 0 → read of 0xC still occurs; err_count = 1, fail_addr = 0x8, fail_exp = 0x03040201, fail_act = 0x03040200, pass = 0.
4. Same fault, stop_on_error = 1 → no AR to 0xC; done asserts after the R handshake at 0x8.
5. BRESP = SLVERR on the write to 0x4 → resp_err = 1, err_count = 1, fail_addr = 0x4, pass = 0.
6. AWREADY delayed 3 cycles, WREADY immediate → WVALID low after 1 cycle, AWADDR stable through the wait. ARESETN pulsed low during RD_RESP → all VALIDs, busy and done go to 0 immediately.
